ioport_reader: RTL and testbench

//  Input/read side of the 2-bit TPI-style port. Samples the external pins and

---
 rtl/ioport_reader_pkg.sv | 13 +
 rtl/ioport_reader_pin_filter.sv | 62 ++++++
 rtl/ioport_reader.sv | 81 ++++++++
 tb/tb_ioport_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioport_reader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ioport_reader_pkg : shared constants for the port read/edge-detect block
// Revision 1.0
// ---------------------------------------------------------------------------
package ioport_reader_pkg;

  // Pins float high when nothing drives them, so every pipeline starts there.
  localparam logic IDLE_LEVEL      = 1'b1;
  localparam int   MIN_SYNC_STAGES = 2;

endpackage : ioport_reader_pkg
`default_nettype wire

// File: rtl/ioport_reader_pin_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pin_filter : per-pin synchroniser, stability filter and one-cycle history
// Revision 1.0
// ---------------------------------------------------------------------------
module pin_filter
  import ioport_reader_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_filt,
  output logic o_filt_prev
);

  // A single-flop chain would defeat metastability protection.
  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int CW     = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(FILTER_CYCLES - 1);

  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_filt;
  logic              r_filt_prev;
  logic              w_sync;

  assign w_sync = r_sync[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{IDLE_LEVEL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_filt      <= IDLE_LEVEL;
      r_filt_prev <= IDLE_LEVEL;
    end else begin
      r_filt_prev <= r_filt;
      if (w_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_filt      = r_filt;
  assign o_filt_prev = r_filt_prev;

endmodule : pin_filter
`default_nettype wire

// File: rtl/ioport_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ioport_reader : CPU read mux, sticky falling-edge flags and masked IRQ
// Revision 1.0
// ---------------------------------------------------------------------------
module ioport_reader
  import ioport_reader_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [WIDTH-1:0] data_ddr,
  input  logic [WIDTH-1:0] data_port,
  input  logic [WIDTH-1:0] data_in,
  input  logic             re_port,
  input  logic             we_mask,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] flags,
  output logic [WIDTH-1:0] mask,
  output logic             irq
);

  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_filt_prev;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ddr_prev;
  logic             r_irq;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pin_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_pin_filter (
      .clk        (clock),
      .rst        (reset),
      .i_pin      (pins_in[i]),
      .o_filt     (w_filt[i]),
      .o_filt_prev(w_filt_prev[i])
    );
  end

  // A bit that was an output last cycle may show a stale fall; ignore it.
  assign w_set = w_filt_prev & ~w_filt & ~data_ddr & ~r_ddr_prev;
  assign w_clr = clr_flags ? data_in : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
      r_flags    <= '0;
      r_mask     <= '0;
      r_ddr_prev <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (re_port) begin
        r_data_out <= (data_ddr & data_port) | (~data_ddr & w_filt);
      end
      if (we_mask) begin
        r_mask <= data_in;
      end
      r_flags    <= (r_flags & ~w_clr) | w_set;
      r_ddr_prev <= data_ddr;
      r_irq      <= |(r_flags & r_mask);
    end
  end

  assign data_out = r_data_out;
  assign flags    = r_flags;
  assign mask     = r_mask;
  assign irq      = r_irq;

endmodule : ioport_reader
`default_nettype wire

// File: tb/tb_ioport_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ioport_reader : directed scenarios plus random traffic against a model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ioport_reader;

  localparam int W = 2;
  localparam int S = 2;
  localparam int F = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pins_in = '0;
  logic [W-1:0] data_ddr = '0;
  logic [W-1:0] data_port = '0;
  logic [W-1:0] data_in = '0;
  logic         re_port = 1'b0;
  logic         we_mask = 1'b0;
  logic         clr_flags = 1'b0;
  logic [W-1:0] data_out;
  logic [W-1:0] flags;
  logic [W-1:0] mask;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pin history per edge; filtered level derived from history windows.
  logic [W-1:0] hist [0:8191];
  int           n    = 0;
  int           base = 1;
  logic [W-1:0] m_filt  = '1;
  logic [W-1:0] m_fprev = '1;
  logic [W-1:0] m_dprev = '0;
  logic [W-1:0] m_flags = '0;
  logic [W-1:0] m_mask  = '0;
  logic [W-1:0] m_dout  = '0;
  logic         m_irq   = 1'b0;

  ioport_reader #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(F)) dut (
    .clock    (clock),
    .reset    (reset),
    .pins_in  (pins_in),
    .data_ddr (data_ddr),
    .data_port(data_port),
    .data_in  (data_in),
    .re_port  (re_port),
    .we_mask  (we_mask),
    .clr_flags(clr_flags),
    .data_out (data_out),
    .flags    (flags),
    .mask     (mask),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] samp(input int k);
    return (k < base) ? {W{1'b1}} : hist[k];
  endfunction

  task automatic model_reset();
    m_filt  = '1;
    m_fprev = '1;
    m_dprev = '0;
    m_flags = '0;
    m_mask  = '0;
    m_dout  = '0;
    m_irq   = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] nf;
    logic [W-1:0] set;
    logic [W-1:0] s;
    logic         all_diff;
    n++;
    hist[n] = pins_in;
    nf = m_filt;
    // The filtered level flips once the pin seen S edges ago has differed for F edges in a row.
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int k = n - S - F + 1; k <= n - S; k++) begin
        s = samp(k);
        if (s[b] == m_filt[b]) all_diff = 1'b0;
      end
      if (all_diff) nf[b] = ~m_filt[b];
    end
    set = m_fprev & ~m_filt & ~data_ddr & ~m_dprev;
    if (re_port) begin
      for (int b = 0; b < W; b++) m_dout[b] = data_ddr[b] ? data_port[b] : m_filt[b];
    end
    m_irq   = |(m_flags & m_mask);
    m_flags = (m_flags & ~(clr_flags ? data_in : '0)) | set;
    if (we_mask) m_mask = data_in;
    m_fprev = m_filt;
    m_filt  = nf;
    m_dprev = data_ddr;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("data_out", 8'(data_out), 8'(m_dout));
    check("flags", 8'(flags), 8'(m_flags));
    check("mask", 8'(mask), 8'(m_mask));
    check("irq", 8'(irq), 8'(m_irq));
    re_port   = 1'b0;
    we_mask   = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic settle(input int k);
    repeat (k) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_data_out", 8'(data_out), 8'h0);
    check("rst_flags", 8'(flags), 8'h0);
    check("rst_mask", 8'(mask), 8'h0);
    check("rst_irq", 8'(irq), 8'h0);
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    base = n + 1;
  endtask

  task automatic clear_all_flags();
    clr_flags = 1'b1;
    data_in   = '1;
    tick();
  endtask

  initial begin
    // Reset with pins low; filt must read idle high for the first 6 edges.
    pins_in = 2'b00;
    #3;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      re_port = 1'b1;
      tick();
      if (i <= 6) check("post_rst_filt_high", 8'(data_out), 8'h3);
      else        check("post_rst_filt_low", 8'(data_out), 8'h0);
    end

    // Glitch reject.
    pins_in = 2'b11;
    settle(10);
    clear_all_flags();
    pins_in = 2'b10;
    settle(3);
    pins_in = 2'b11;
    settle(10);
    re_port = 1'b1;
    tick();
    check("glitch_flags", 8'(flags), 8'h0);
    check("glitch_read", 8'(data_out), 8'h3);

    // Falling edge to flag to irq, then clear.
    we_mask = 1'b1;
    data_in = 2'b01;
    tick();
    pins_in = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) check("fall_flags_e6", 8'(flags), 8'h0);
      if (i == 7) begin
        check("fall_flags_e7", 8'(flags), 8'h1);
        check("fall_irq_e7", 8'(irq), 8'h0);
      end
      if (i == 8) check("fall_irq_e8", 8'(irq), 8'h1);
    end
    clr_flags = 1'b1;
    data_in   = 2'b01;
    tick();
    check("clr_flags", 8'(flags), 8'h0);
    check("clr_irq_lag", 8'(irq), 8'h1);
    tick();
    check("clr_irq_low", 8'(irq), 8'h0);

    // Read mux with one output bit.
    data_ddr  = 2'b10;
    data_port = 2'b10;
    pins_in   = 2'b01;
    settle(10);
    re_port = 1'b1;
    tick();
    check("read_mux_11", 8'(data_out), 8'h3);
    pins_in = 2'b00;
    settle(10);
    re_port = 1'b1;
    tick();
    check("read_mux_10", 8'(data_out), 8'h2);

    // Set wins over a same-cycle clear.
    data_ddr = 2'b00;
    pins_in  = 2'b11;
    settle(10);
    clear_all_flags();
    pins_in = 2'b01;
    settle(6);
    clr_flags = 1'b1;
    data_in   = 2'b10;
    tick();
    check("set_beats_clr", 8'(flags), 8'h2);

    // Direction switch suppresses the edge.
    pins_in  = 2'b11;
    data_ddr = 2'b10;
    settle(10);
    clear_all_flags();
    pins_in = 2'b01;
    settle(6);
    data_ddr = 2'b00;
    settle(4);
    check("dir_switch_noflag", 8'(flags), 8'h0);

    // Reset in the middle of a filter run.
    pins_in = 2'b11;
    settle(10);
    clear_all_flags();
    pins_in = 2'b00;
    settle(4);
    pins_in = 2'b11;
    do_reset();
    settle(10);
    check("midfilter_rst_noflag", 8'(flags), 8'h0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) pins_in[0] = ~pins_in[0];
        else                           pins_in[1] = ~pins_in[1];
      end
      if ($urandom_range(0, 40) == 0) data_ddr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) data_port = 2'($urandom_range(0, 3));
      data_in   = 2'($urandom_range(0, 3));
      re_port   = ($urandom_range(0, 1) == 1);
      we_mask   = ($urandom_range(0, 9) == 0);
      clr_flags = ($urandom_range(0, 6) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ioport_reader
`default_nettype wire
